// File: rtl/tick_period_meter.sv
// rtl/tick_period_meter.sv - measures clk cycles between synchronized rising edges of sig_in
// Results are delivered through a single-entry valid/ready output register.
module tick_period_meter #(
   parameter int WIDTH       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period_out,
   output logic             ovf_out,
   output logic             valid,
   input  logic             ready,
   output logic             lost,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   rise;
   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       count_q, count_d;
   logic [WIDTH-1:0]       period_q;
   logic                   ovf_q, valid_q, lost_q, busy_q;
   logic                   res_fire;
   logic [WIDTH-1:0]       res_period;
   logic                   res_ovf;

   assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      res_fire   = 1'b0;
      res_period = count_q;
      res_ovf    = 1'b0;
      case (state_q)
         IDLE: begin
            count_d = '0;
            state_d = ARM;
         end
         ARM: begin
            if (rise) begin
               state_d = MEAS;
               count_d = WIDTH'(1);
            end
         end
         MEAS: begin
            // An edge on the saturation cycle still wins as a normal result.
            if (rise) begin
               res_fire = 1'b1;
               count_d  = WIDTH'(1);
            end else if (count_q == CNT_MAX) begin
               res_fire   = 1'b1;
               res_period = CNT_MAX;
               res_ovf    = 1'b1;
               count_d    = '0;
               state_d    = ARM;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
      if (!en) begin
         state_d  = IDLE;
         count_d  = '0;
         res_fire = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         dly_q    <= 1'b0;
         state_q  <= IDLE;
         count_q  <= '0;
         period_q <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         lost_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         dly_q  <= sync_q[SYNC_STAGES-1];
         if (clr) begin
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
            count_q <= '0;
            state_q <= en ? ARM : IDLE;
            busy_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d == MEAS);
            // A held result is never overwritten; a new one is dropped instead.
            if (res_fire) begin
               if (!valid_q || ready) begin
                  period_q <= res_period;
                  ovf_q    <= res_ovf;
                  valid_q  <= 1'b1;
               end else begin
                  lost_q <= 1'b1;
               end
            end else if (valid_q && ready) begin
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign period_out = period_q;
   assign ovf_out    = ovf_q;
   assign valid      = valid_q;
   assign lost       = lost_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// tb/tb_tick_period_meter.sv - randomized bench for tick_period_meter against a timestamp model
// The model measures periods as differences of edge timestamps, not with a counter.
module tb_tick_period_meter;

   localparam int W   = 8;
   localparam int S   = 2;
   localparam int MAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst, en, clr, sig_in, ready;
   logic [W-1:0] period_out;
   logic         ovf_out, valid, lost, busy;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int   m_mode;     // 0 idle, 1 waiting for first edge, 2 measuring
   int   m_tstart;
   int   m_cyc = 0;
   logic m_valid, m_lost, m_ovf;
   int   m_period;
   logic m_hist [1:S+1];

   tick_period_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .sig_in     (sig_in),
      .period_out (period_out),
      .ovf_out    (ovf_out),
      .valid      (valid),
      .ready      (ready),
      .lost       (lost),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, m_cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_tstart = 0;
      m_valid  = 1'b0;
      m_lost   = 1'b0;
      m_ovf    = 1'b0;
      m_period = 0;
      for (int i = 1; i <= S + 1; i++) m_hist[i] = 1'b0;
   endtask

   // Advances the model across the next rising clock edge with the given inputs.
   task automatic model_step(input logic e, input logic c, input logic s, input logic r);
      logic rise_now, res, ro;
      int   rp, el;
      rise_now = m_hist[S] && !m_hist[S+1];
      res = 1'b0; ro = 1'b0; rp = 0;
      if (c) begin
         m_valid = 1'b0;
         m_lost  = 1'b0;
         m_mode  = e ? 1 : 0;
      end else begin
         if (!e) m_mode = 0;
         else if (m_mode == 0) m_mode = 1;
         else if (m_mode == 1) begin
            if (rise_now) begin
               m_mode   = 2;
               m_tstart = m_cyc;
            end
         end else begin
            el = m_cyc - m_tstart;
            if (rise_now) begin
               res = 1'b1; rp = el; ro = 1'b0;
               m_tstart = m_cyc;
            end else if (el == MAX) begin
               res = 1'b1; rp = MAX; ro = 1'b1;
               m_mode = 1;
            end
         end
         if (res) begin
            if (!m_valid || r) begin
               m_valid  = 1'b1;
               m_period = rp;
               m_ovf    = ro;
            end else begin
               m_lost = 1'b1;
            end
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
      end
      for (int i = S + 1; i >= 2; i--) m_hist[i] = m_hist[i-1];
      m_hist[1] = s;
      m_cyc++;
   endtask

   task automatic compare_outputs();
      check("valid", 32'(valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_mode == 2));
      check("lost", 32'(lost), 32'(m_lost));
      check("period_out", 32'(period_out), 32'(m_period));
      check("ovf_out", 32'(ovf_out), 32'(m_ovf));
   endtask

   task automatic body(input logic e, input logic c, input logic s, input logic r);
      compare_outputs();
      en = e; clr = c; sig_in = s; ready = r;
      model_step(e, c, s, r);
   endtask

   task automatic cycle(input logic e, input logic c, input logic s, input logic r);
      @(negedge clk);
      body(e, c, s, r);
   endtask

   int ph = 0;

   task automatic run_phase(input int ncyc, input int per, input int hi, input int rdy_pct,
                            input int en_off_pct, input int clr_pct);
      logic e, c, s, r;
      for (int k = 0; k < ncyc; k++) begin
         s = ((ph % per) < hi);
         ph++;
         r = ($urandom_range(99) < rdy_pct);
         e = ($urandom_range(99) >= en_off_pct);
         c = ($urandom_range(99) < clr_pct);
         cycle(e, c, s, r);
      end
   endtask

   task automatic async_reset_with_high_input();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_lost", 32'(lost), 32'd0);
      check("rst_period", 32'(period_out), 32'd0);
      check("rst_ovf", 32'(ovf_out), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      body(1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; sig_in = 1'b0; ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_outputs();
      rst = 1'b0;

      ph = 0; run_phase(200, 10, 1, 100, 0, 0);
      ph = 0; run_phase(1300, 300, 3, 100, 0, 0);
      ph = 0; run_phase(120, 16, 2, 0, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      ph = 0; run_phase(60, 12, 3, 100, 0, 0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      ph = 0; run_phase(60, 12, 3, 100, 0, 0);
      async_reset_with_high_input();
      ph = 0; run_phase(100, 2, 1, 100, 0, 0);

      for (int p = 0; p < 25; p++) begin
         int per;
         per = $urandom_range(40, 2);
         ph = 0;
         run_phase($urandom_range(300, 80), per, $urandom_range(per - 1, 1),
                   $urandom_range(100, 0), $urandom_range(3, 0), $urandom_range(2, 0));
      end
      ph = 0; run_phase(700, 280, 5, 50, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
